// File: rtl/riscv_enc_pkg.sv
// Shared RISC-V encoder types: immediate formats (same encoding as the extend unit's immsrc),
// opcode constants and the decoded-field bundle carried through the encoder pipeline.
package riscv_enc_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_fmt_t;

    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_LOAD   = 7'h03;

    typedef struct packed {
        imm_fmt_t    fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [31:0] imm;
    } enc_fields_t;

endpackage

// File: rtl/imm_pack.sv
// Field packer: scatters the immediate into the format's instruction bit positions; optional range check (ENC_RANGE_CHECK_EN).
// Latency: combinational. Backpressure: none (sits between pipeline stages).
module imm_pack
    import riscv_enc_pkg::*;
(
    input  enc_fields_t f,
    output logic [31:0] instr,
    output logic        err
);

    always_comb begin
        instr = 32'h0;
        case (f.fmt)
            IMM_I: instr = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
            IMM_S: instr = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
            IMM_B: instr = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                            f.imm[4:1], f.imm[11], f.opcode};
            IMM_J: instr = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
            default: instr = 32'h0;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    // Representable iff every bit above the format's sign bit copies it; B/J also need an even offset.
    always_comb begin
        err = 1'b0;
        case (f.fmt)
            IMM_I, IMM_S: err = !((&f.imm[31:11]) || !(|f.imm[31:11]));
            IMM_B:        err = !((&f.imm[31:12]) || !(|f.imm[31:12])) || f.imm[0];
            IMM_J:        err = !((&f.imm[31:20]) || !(|f.imm[31:20])) || f.imm[0];
            default:      err = 1'b0;
        endcase
    end
`else
    logic unused_imm;
    assign unused_imm = ^{f.imm[31:21], f.imm[0]};
    assign err = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Pipelined RISC-V instruction encoder (fields -> 32-bit word); range check built when ENC_RANGE_CHECK_EN is defined.
// Latency: 2 cycles accept-to-out_valid, 1 word/cycle. Backpressure: 2-deep valid/ready chain, in_ready combinational from out_ready.
module instr_encoder
    import riscv_enc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       fmt,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr,
    output logic             err,
    output logic [CNT_W-1:0] word_count
);

    logic        s1_valid;
    enc_fields_t s1_dat;
    logic        s2_valid;
    logic [31:0] s2_instr;
    logic        s2_err;
    logic        s1_adv;
    logic        s2_adv;
    logic [31:0] pk_instr;
    logic        pk_err;
    enc_fields_t in_dat;

    assign in_dat = '{fmt: imm_fmt_t'(fmt), opcode: opcode, rd: rd, rs1: rs1,
                      rs2: rs2, funct3: funct3, imm: imm};

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    imm_pack u_pack (
        .f     (s1_dat),
        .instr (pk_instr),
        .err   (pk_err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_dat     <= '0;
            s2_valid   <= 1'b0;
            s2_instr   <= 32'h0;
            s2_err     <= 1'b0;
            word_count <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) s1_dat <= in_dat;
            end
            // S2 only reloads when empty or draining, so a stalled word never changes.
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_instr <= pk_instr;
                    s2_err   <= pk_err;
                end
            end
            if (s2_valid && out_ready) word_count <= word_count + CNT_W'(1);
        end
    end

    assign out_valid = s2_valid;
    assign instr     = s2_instr;
    assign err       = s2_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vectors, flow control, reset, then random traffic against a queue model.
module tb_instr_encoder;

    typedef struct packed {
        logic [1:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [31:0] imm;
    } fld_t;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [1:0]  fmt;
        logic [31:0] imm;
        int          acc;
    } exp_t;

`ifdef ENC_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  fmt = 2'b0;
    logic [6:0]  opcode = 7'h0;
    logic [4:0]  rd = 5'h0, rs1 = 5'h0, rs2 = 5'h0;
    logic [2:0]  funct3 = 3'h0;
    logic [31:0] imm = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] instr;
    logic        err;
    logic [15:0] word_count;

    always #5 clk = ~clk;

    instr_encoder #(.CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fmt        (fmt),
        .opcode     (opcode),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .funct3     (funct3),
        .imm        (imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .instr      (instr),
        .err        (err),
        .word_count (word_count)
    );

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    exp_t        q[$];
    logic [15:0] mcount = 16'h0;
    logic [31:0] last_instr = 32'h0;
    logic        last_err = 1'b0;
    logic        hold = 1'b0;
    logic [31:0] hold_instr = 32'h0;
    logic        accepted = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference encoding written straight from the format layouts.
    function automatic logic [31:0] model_enc(input fld_t f);
        logic [31:0] i;
        i = f.imm;
        case (f.fmt)
            2'b00:   return {i[11:0], f.rs1, f.f3, f.rd, f.op};
            2'b01:   return {i[11:5], f.rs2, f.rs1, f.f3, i[4:0], f.op};
            2'b10:   return {i[12], i[10:5], f.rs2, f.rs1, f.f3, i[4:1], i[11], f.op};
            default: return {i[20], i[10:1], i[11], i[19:12], f.rd, f.op};
        endcase
    endfunction

    // The datapath's extend unit: gathers the immediate back out of instr[31:7].
    function automatic logic [31:0] extend(input logic [24:0] b, input logic [1:0] fm);
        case (fm)
            2'b00:   return {{20{b[24]}}, b[24:13]};
            2'b01:   return {{20{b[24]}}, b[24:18], b[4:0]};
            2'b10:   return {{19{b[24]}}, b[24], b[0], b[23:18], b[4:1], 1'b0};
            default: return {{11{b[24]}}, b[24], b[12:5], b[13], b[23:14], 1'b0};
        endcase
    endfunction

    function automatic logic representable(input logic [1:0] fm, input logic [31:0] v);
        int s;
        s = $signed(v);
        case (fm)
            2'b00, 2'b01: return (s >= -2048) && (s <= 2047);
            2'b10:        return (s >= -4096) && (s <= 4095) && !v[0];
            default:      return (s >= -(1 << 20)) && (s <= (1 << 20) - 1) && !v[0];
        endcase
    endfunction

    function automatic fld_t mk(input logic [1:0] fm, input logic [6:0] op, input logic [4:0] d,
                                input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                                input logic [31:0] v);
        fld_t f;
        f.fmt = fm; f.op = op; f.rd = d; f.rs1 = s1; f.rs2 = s2; f.f3 = f3; f.imm = v;
        return f;
    endfunction

    function automatic fld_t rnd_fld();
        fld_t        f;
        logic [31:0] r;
        r = $urandom;
        f.fmt = 2'($urandom_range(0, 3));
        f.op  = 7'($urandom); f.rd = 5'($urandom); f.rs1 = 5'($urandom);
        f.rs2 = 5'($urandom); f.f3 = 3'($urandom);
        case ($urandom_range(0, 4))
            0:       f.imm = r;
            1:       f.imm = $signed(r << 20) >>> 20;
            2:       f.imm = ($signed(r << 19) >>> 19) & 32'hFFFF_FFFE;
            3:       f.imm = ($signed(r << 11) >>> 11) & 32'hFFFF_FFFE;
            default: f.imm = $signed(r << 18) >>> 18;
        endcase
        return f;
    endfunction

    // One clock: drive at the falling edge, check 1 time unit later, log the handshakes of the coming edge.
    task automatic cycle(input logic iv, input fld_t f, input logic ordy);
        exp_t e;
        logic exp_ov;
        @(negedge clk);
        in_valid = iv; fmt = f.fmt; opcode = f.op; rd = f.rd; rs1 = f.rs1;
        rs2 = f.rs2; funct3 = f.f3; imm = f.imm; out_ready = ordy;
        #1;
        exp_ov = (q.size() > 0) && (cyc >= q[0].acc + 1);
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
        chk("in_ready", {31'b0, in_ready}, {31'b0, !(q.size() == 2 && !ordy)});
        chk("word_count", {16'b0, word_count}, {16'b0, mcount});
        if (hold) begin
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_instr", instr, hold_instr);
        end
        if (out_valid && q.size() > 0) begin
            chk("instr", instr, q[0].instr);
            chk("err", {31'b0, err}, {31'b0, q[0].err});
        end
        hold = out_valid && !ordy;
        hold_instr = instr;
        if (out_valid && ordy && q.size() > 0) begin
            e = q.pop_front();
            last_instr = instr;
            last_err = err;
            mcount++;
            if (representable(e.fmt, e.imm))
                chk("roundtrip", extend(instr[31:7], e.fmt), e.imm);
        end
        accepted = iv && in_ready;
        if (accepted) begin
            e.instr = model_enc(f);
            e.err   = RC && !representable(f.fmt, f.imm);
            e.fmt   = f.fmt;
            e.imm   = f.imm;
            e.acc   = cyc + 1;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        fld_t idle;
        idle = '0;
        for (int i = 0; i < 20 && q.size() > 0; i++) cycle(1'b0, idle, 1'b1);
        if (q.size() > 0) chk("drain_timeout", q.size(), 0);
    endtask

    task automatic send(input fld_t f);
        cycle(1'b1, f, 1'b1);
        if (!accepted) chk("send_accept", 32'd0, 32'd1);
        drain();
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_word_count", {16'b0, word_count}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        q.delete();
        mcount = 16'h0;
        hold = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        fld_t fi, fs, fb, fj, w0, w1, w2, idle;
        idle = '0;
        fi = mk(2'b00, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 32'hFFFF_FFFF);
        fs = mk(2'b01, 7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 32'h0000_0008);
        fb = mk(2'b10, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_FFFC);
        fj = mk(2'b11, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0800);

        #1;
        chk("init_out_valid", {31'b0, out_valid}, 32'd0);
        chk("init_in_ready", {31'b0, in_ready}, 32'd1);
        chk("init_word_count", {16'b0, word_count}, 32'd0);
        chk("init_instr", instr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        chk("model_I", model_enc(fi), 32'hFFF3_0293);
        chk("model_S", model_enc(fs), 32'h0021_A423);
        chk("model_B", model_enc(fb), 32'hFE20_8EE3);
        chk("model_J", model_enc(fj), 32'h0010_00EF);
        chk("model_ext_B", extend(model_enc(fb) >> 7, 2'b10), 32'hFFFF_FFFC);

        // Directed I word, with explicit two-cycle latency.
        cycle(1'b1, fi, 1'b1);
        cycle(1'b0, idle, 1'b1);
        chk("lat_I_early", {31'b0, out_valid}, 32'd0);
        cycle(1'b0, idle, 1'b1);
        chk("lat_I_due", {31'b0, out_valid}, 32'd1);
        chk("dir_I", last_instr, 32'hFFF3_0293);
        chk("dir_I_err", {31'b0, last_err}, 32'd0);
        send(fs); chk("dir_S", last_instr, 32'h0021_A423);
        send(fb); chk("dir_B", last_instr, 32'hFE20_8EE3);
        send(fj); chk("dir_J", last_instr, 32'h0010_00EF);

        send(mk(2'b00, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 32'h0000_0800));
        chk("rng_I", last_instr, 32'h8003_0293);
        chk("rng_I_err", {31'b0, last_err}, {31'b0, RC});
        send(mk(2'b10, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'h0000_0003));
        chk("rng_B", last_instr, 32'h0020_8163);
        chk("rng_B_err", {31'b0, last_err}, {31'b0, RC});
        send(mk(2'b11, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0010_0000));
        chk("rng_J", last_instr, 32'h8000_00EF);
        chk("rng_J_err", {31'b0, last_err}, {31'b0, RC});

        // Backpressure: two words fill the pipe, the third is refused until out_ready rises.
        do_reset();
        w0 = mk(2'b00, 7'h03, 5'd1, 5'd2, 5'd0, 3'd2, 32'h0000_0010);
        w1 = mk(2'b01, 7'h23, 5'd0, 5'd4, 5'd5, 3'd2, 32'hFFFF_FFF0);
        w2 = mk(2'b10, 7'h63, 5'd0, 5'd7, 5'd8, 3'd1, 32'h0000_0100);
        cycle(1'b1, w0, 1'b0);
        cycle(1'b1, w1, 1'b0);
        cycle(1'b1, w2, 1'b0);
        chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        cycle(1'b1, w2, 1'b0);
        chk("bp_hold", {31'b0, in_ready}, 32'd0);
        for (int i = 0; i < 5 && !accepted; i++) cycle(1'b1, w2, 1'b1);
        if (!accepted) chk("bp_accept_timeout", 32'd0, 32'd1);
        drain();
        cycle(1'b0, idle, 1'b1);
        chk("bp_word_count", {16'b0, word_count}, 32'd3);

        // Reset with two words in flight, then a fresh word must take two cycles again.
        cycle(1'b1, w0, 1'b0);
        cycle(1'b1, w1, 1'b0);
        do_reset();
        cycle(1'b1, fj, 1'b1);
        cycle(1'b0, idle, 1'b1);
        chk("post_rst_early", {31'b0, out_valid}, 32'd0);
        cycle(1'b0, idle, 1'b1);
        chk("post_rst_due", {31'b0, out_valid}, 32'd1);
        chk("post_rst_instr", instr, 32'h0010_00EF);
        drain();

        for (int i = 0; i < 1500; i++)
            cycle($urandom_range(0, 3) != 0, rnd_fld(), $urandom_range(0, 3) != 0);
        drain();
        cycle(1'b0, idle, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Pipelined RISC-V instruction encoder. It is the inverse of the datapath's immediate extend unit: it takes decoded fields (format, opcode, register indices, funct3, 32-bit immediate) and packs them into a 32-bit instruction word. The immediate is scattered into the same bit positions the extend unit gathers it from. The block sits between the test-program generator / boot loader and instruction memory, and streams encoded words under a valid/ready handshake.

## Interface
Parameters:
- CNT_W, 16, width of the encoded-word counter

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high
- in_valid  input  1  input fields valid
- in_ready  output  1  encoder can accept fields this cycle
- fmt  input  2  immediate format; same encoding as the extend unit's immsrc: 00 I, 01 S, 10 B, 11 J
- opcode  input  7  instr[6:0]
- rd  input  5  destination register (I, J)
- rs1  input  5  source 1 (I, S, B)
- rs2  input  5  source 2 (S, B)
- funct3  input  3  instr[14:12] (I, S, B)
- imm  input  32  sign-extended byte immediate
- out_valid  output  1  instr valid
- out_ready  input  1  consumer accepts instr
- instr  output  32  encoded instruction
- err  output  1  immediate not representable in fmt (travels with instr)
- word_count  output  CNT_W  number of output handshakes since reset

## Operation
- Encoding, per fmt:
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Fields unused by a format are ignored.
- Round-trip invariant: when err=0, extend(instr[31:7], fmt) == imm.
- Two register stages:
  - S1 captures the raw fields.
  - S2 captures the encoded instr and err.
- Ready chain:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv (combinational from out_ready)
- Input handshake occurs when in_valid && in_ready. Output handshake occurs when out_valid && out_ready.
- Words leave strictly in acceptance order. None are dropped or duplicated.
- word_count increments by 1 on each output handshake and wraps modulo 2^CNT_W.
- out_valid must not drop, and instr/err must not change, while out_valid && !out_ready.

## Timing
- Reset values: out_valid 0, instr 0, err 0, word_count 0, both stage valids 0. in_ready is 1 out of reset.
- Latency: fields accepted at edge k cause out_valid=1 with the word after edge k+1 (2 cycles).
- Throughput: 1 word/cycle when out_ready stays high.
- Backpressure with out_ready=0: the pipeline holds 2 words, then in_ready=0.
- Simultaneous input and output handshake on a full pipeline: permitted. Both stages shift in the same edge.
- Reset mid-stream: in-flight words are discarded. out_valid=0 immediately (asynchronous). word_count is cleared.

## Configuration
- ENC_RANGE_CHECK_EN defined:
  - err=1 when imm is not representable in fmt:
    - I/S: imm[31:11] not all equal
    - B: imm[31:12] not all equal, or imm[0]=1
    - J: imm[31:20] not all equal, or imm[0]=1
  - instr is still produced from the truncated bits.
- ENC_RANGE_CHECK_EN undefined: err is tied to 0 and no check logic is synthesised.

## Structure
- Package riscv_enc_pkg holds:
  - imm_fmt_t enum: IMM_I=2'b00, IMM_S=2'b01, IMM_B=2'b10, IMM_J=2'b11, shared with the extend unit's immsrc
  - opcode constants: OP_IMM 7'h13, OP_STORE 7'h23, OP_BRANCH 7'h63, OP_JAL 7'h6F, OP_LOAD 7'h03
- Sub-module imm_pack: purely combinational field packer and range check, between S1 and S2.

## Test plan
- I, opcode 0x13, rd 5, rs1 6, funct3 0, imm 0xFFFFFFFF -> instr 0xFFF30293, err 0, out_valid two cycles after acceptance.
- S, opcode 0x23, funct3 2, rs1 3, rs2 2, imm 8 -> instr 0x0021A423.
- B, opcode 0x63, funct3 0, rs1 1, rs2 2, imm 0xFFFFFFFC -> 0xFE208EE3.
- J, opcode 0x6F, rd 1, imm 0x800 -> 0x001000EF.
- Each output is also fed through extend and checked to return imm.
- Range check with the macro defined:
  - I imm 0x800 -> err 1
  - B imm 3 -> err 1
  - J imm 0x100000 -> err 1
- Range check with the macro undefined: the same stimuli give err 0 and identical instr.
- Flow control:
  - out_ready=0 while offering 3 words -> in_ready falls after 2 accepts.
  - Then raise out_ready -> 3 words in order, word_count=3.
  - Assert reset mid-stream -> out_valid 0 at once, word_count 0, next word's latency is again 2 cycles.
